// File: rtl/wb_pkg.sv
// Shared Wishbone B4 types and burst-address helper for the slave memory
// and future bridge blocks.
package wb_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SINGLE = 3'd2,
        BURST  = 3'd3,
        TERM   = 3'd4
    } wb_state_e;

    // Wrapping bursts only move the low index bits; the rest of the index is held.
    function automatic logic [31:0] next_burst_idx(input logic [31:0] idx, input bte_e bte);
        logic [31:0] nxt;
        nxt = idx;
        case (bte)
            WRAP4:   nxt[1:0] = idx[1:0] + 2'd1;
            WRAP8:   nxt[2:0] = idx[2:0] + 3'd1;
            WRAP16:  nxt[3:0] = idx[3:0] + 4'd1;
            default: nxt      = idx + 32'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wb_mem_bytewr.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enable,
// registered read of the addressed word every cycle.
module wb_mem_bytewr #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B4 slave over an internal word memory: classic cycles, incrementing
// CTI/BTE bursts, programmable first-beat wait states, err and rty terminations.
module wb_slave_mem
    import wb_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic [2:0]  cti_i,
    input  logic [1:0]  bte_i,
    input  logic        hold_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    wb_state_e     state;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] burst_idx;
    logic          is_burst;
    logic          is_miss;
    logic          ovf;
    logic          ack;
    logic          err;
    logic          rty;
    logic [31:0]   rdata;

    logic          req;
    logic          hit;
    logic [31:0]   offset;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] next_idx;
    logic          beat;
    logic          beat_ovf;
    logic          ovf_next;
    logic          first_fire;
    logic          first_miss;
    logic          first_burst;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;

    // Handshake: the initiator holds cyc/stb and its request until it sees a
    // termination; a transfer completes on the rising edge where cyc_i, stb_i
    // and exactly one of ack_o/err_o/rty_o are high together.
    always_comb begin
        offset   = adr_i - BASE_ADDR;
        hit      = (offset < WIN_BYTES) && (adr_i[1:0] == 2'b00);
        req_idx  = offset[AW+1:2];
        req      = cyc_i & stb_i;
        beat     = (state == BURST) & ack & req;
        next_idx = AW'(next_burst_idx(32'(burst_idx), bte_e'(bte_i)));
        beat_ovf = beat && (bte_e'(bte_i) == LINEAR) && (burst_idx == LAST_IDX);
        ovf_next = ovf | beat_ovf;

        first_fire  = 1'b0;
        first_miss  = is_miss;
        first_burst = is_burst;
        if (state == IDLE) begin
            first_fire  = req && !hold_i && (WS == 4'd0);
            first_miss  = !hit;
            first_burst = (cti_i == INCR);
        end else if (state == WAIT) begin
            first_fire = (wait_cnt <= 4'd1);
        end

        // Reads fetch one cycle ahead of the ack; writes stay on the acked beat.
        mem_addr = burst_idx;
        if (state == IDLE) begin
            mem_addr = req_idx;
        end else if (beat && !we_i) begin
            mem_addr = next_idx;
        end
        mem_be = (ack && req && we_i) ? sel_i : 4'b0000;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            burst_idx <= '0;
            is_burst  <= 1'b0;
            is_miss   <= 1'b0;
            ovf       <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rty       <= 1'b0;
        end else if (!cyc_i) begin
            state <= IDLE;
            ovf   <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rty   <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            rty <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        burst_idx <= req_idx;
                        is_burst  <= (cti_i == INCR);
                        is_miss   <= !hit;
                        ovf       <= 1'b0;
                        wait_cnt  <= WS;
                        if (hold_i) begin
                            rty   <= 1'b1;
                            state <= TERM;
                        end else if (!first_fire) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!first_fire) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                SINGLE, TERM: state <= IDLE;
                BURST: begin
                    if (beat && (cti_i == EOB)) begin
                        state <= IDLE;
                    end else begin
                        if (beat && !beat_ovf) begin
                            burst_idx <= next_idx;
                        end
                        ovf <= ovf_next;
                        // A linear burst that ran off the window ends on an err beat.
                        if (stb_i) begin
                            if (ovf_next) begin
                                err   <= 1'b1;
                                state <= TERM;
                            end else begin
                                ack <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (first_fire) begin
                if (first_miss) begin
                    err   <= 1'b1;
                    state <= TERM;
                end else begin
                    ack   <= 1'b1;
                    state <= first_burst ? BURST : SINGLE;
                end
            end
        end
    end

    wb_mem_bytewr #(
        .DEPTH(DEPTH_WORDS)
    ) u_mem (
        .clk  (clk_i),
        .addr (mem_addr),
        .be   (mem_be),
        .wdata(dat_i),
        .rdata(rdata)
    );

    assign ack_o = ack;
    assign err_o = err;
    assign rty_o = rty;
    assign dat_o = ack ? rdata : 32'h0;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: one instance with no wait states and
// one with three, sharing the bus but selected by their own cyc line.
module tb_wb_slave_mem;

    localparam int         EW    = 35;
    localparam logic [1:0] K_ACK = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;
    localparam logic [1:0] K_RTY = 2'd3;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        hold;
    logic        dut_sel;

    logic        cyc_a, cyc_b;
    logic [31:0] dat_a, dat_b;
    logic        ack_a, ack_b, err_a, err_b, rty_a, rty_b;
    logic [31:0] m_dat;
    logic        m_ack, m_err, m_rty;

    logic [EW-1:0] exp_q[$];
    int n_checks;
    int n_pass;

    assign cyc_a = cyc & ~dut_sel;
    assign cyc_b = cyc & dut_sel;
    assign m_dat = dut_sel ? dat_b : dat_a;
    assign m_ack = dut_sel ? ack_b : ack_a;
    assign m_err = dut_sel ? err_b : err_a;
    assign m_rty = dut_sel ? rty_b : rty_a;

    wb_slave_mem #(.WAIT_STATES(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc_a), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
        .hold_i(hold), .dat_o(dat_a), .ack_o(ack_a), .err_o(err_a), .rty_o(rty_a)
    );

    wb_slave_mem #(.WAIT_STATES(3)) u_dut_ws3 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc_b), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .sel_i(sel), .cti_i(cti), .bte_i(bte),
        .hold_i(hold), .dat_o(dat_b), .ack_o(ack_b), .err_o(err_b), .rty_o(rty_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic term();
        return m_ack | m_err | m_rty;
    endfunction

    task automatic expect_term(input logic [1:0] kind, input logic [31:0] d, input logic chk);
        exp_q.push_back({chk, kind, d});
    endtask

    // Scoreboard: every termination cycle of the selected DUT pops one expectation.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [1:0]    kind;
        if (!rst && term()) begin
            check("term_onehot", 64'($onehot({m_ack, m_err, m_rty})), 64'd1);
            kind = m_ack ? K_ACK : (m_err ? K_ERR : K_RTY);
            if (exp_q.size() == 0) begin
                check("unexpected_term", 64'(kind), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("term_kind", 64'(kind), 64'(e[33:32]));
                if (e[34]) check("dat_o", 64'(m_dat), 64'(e[31:0]));
            end
        end
    end

    function automatic int lat();
        return dut_sel ? 4 : 1;
    endfunction

    // Driver tasks
    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic h);
        int n;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; cti = 3'b000; hold = h;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!term() && n < 40);
        check("classic_latency", 64'(n), 64'(lat()));
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; hold = 1'b0;
        check("classic_one_cycle", 64'(term()), 64'd0);
    endtask

    task automatic burst(input logic w, input logic [31:0] a, input logic [31:0] d0,
                         input logic [1:0] b, input int nb, input int abort_after);
        int n;
        logic aborted;
        aborted = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d0; sel = 4'hF; bte = b; hold = 1'b0;
        cti = (nb == 1) ? 3'b111 : 3'b010;
        for (int k = 0; k < nb; k++) begin
            n = 0;
            while (!term() && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            if (k == 0) check("burst_first_latency", 64'(n), 64'(lat()));
            else        check("burst_continuous", 64'(n), 64'd0);
            @(posedge clk); #1;
            if (k + 1 == nb) break;
            if (k + 1 == abort_after) begin
                aborted = 1'b1;
                break;
            end
            adr = adr + 32'd4;
            dat = d0 + 32'(k + 1);
            cti = (k + 2 == nb) ? 3'b111 : 3'b010;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        if (aborted) begin
            @(posedge clk); #1;
            check("abort_outputs_idle", 64'({m_ack, m_err, m_rty}), 64'd0);
        end else begin
            check("burst_end_idle", 64'(term()), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] full, part, model;
        logic [3:0]  s;
        int          widx, n;

        n_checks = 0; n_pass = 0;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0;
        sel = '0; cti = '0; bte = '0; hold = 1'b0; dut_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 64'({ack_a, err_a, rty_a}), 64'd0);
        check("reset_a_dat", 64'(dat_a), 64'd0);
        check("reset_b", 64'({ack_b, err_b, rty_b}), 64'd0);
        check("reset_b_dat", 64'(dat_b), 64'd0);
        rst = 1'b0;

        // Classic write and read, no wait states
        expect_term(K_ACK, 32'h0, 1'b0);
        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        expect_term(K_ACK, 32'hDEADBEEF, 1'b1);
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

        // Three wait states, partial byte write
        dut_sel = 1'b1;
        expect_term(K_ACK, 32'h0, 1'b0);
        classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b0);
        classic(1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0);
        expect_term(K_ACK, 32'hFF22FF44, 1'b1);
        classic(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        expect_term(K_ERR, 32'h0, 1'b1);
        classic(1'b0, 32'h404, 32'h0, 4'hF, 1'b0);
        dut_sel = 1'b0;

        // Preload words 0..15 with their index, then a wrap4 read burst from word 14
        for (int i = 0; i < 16; i++) begin
            expect_term(K_ACK, 32'h0, 1'b0);
            classic(1'b1, 32'(i * 4), 32'(i), 4'hF, 1'b0);
        end
        expect_term(K_ACK, 32'd14, 1'b1);
        expect_term(K_ACK, 32'd15, 1'b1);
        expect_term(K_ACK, 32'd12, 1'b1);
        expect_term(K_ACK, 32'd13, 1'b1);
        burst(1'b0, 32'h38, 32'h0, 2'b01, 4, 0);

        // Error terminations
        expect_term(K_ERR, 32'h0, 1'b1);
        classic(1'b0, 32'h400, 32'h0, 4'hF, 1'b0);
        expect_term(K_ERR, 32'h0, 1'b1);
        classic(1'b0, 32'h02, 32'h0, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b0);
        expect_term(K_ERR, 32'h0, 1'b1);
        burst(1'b1, 32'h3FC, 32'hAAAA5555, 2'b00, 2, 0);
        expect_term(K_ACK, 32'hAAAA5555, 1'b1);
        classic(1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b1);
        classic(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);

        // Retry while busy, then complete
        expect_term(K_ACK, 32'h0, 1'b0);
        classic(1'b1, 32'h40, 32'h01020304, 4'hF, 1'b0);
        expect_term(K_RTY, 32'h0, 1'b1);
        classic(1'b1, 32'h40, 32'h0BADF00D, 4'hF, 1'b1);
        expect_term(K_ACK, 32'h01020304, 1'b1);
        classic(1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b0);
        classic(1'b1, 32'h40, 32'h0BADF00D, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b0);
        classic(1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 1'b0);
        expect_term(K_ACK, 32'h0BADF00D, 1'b1);
        classic(1'b0, 32'h40, 32'h0, 4'hF, 1'b0);

        // Abort a write burst after two beats
        expect_term(K_ACK, 32'h0, 1'b0);
        classic(1'b1, 32'h88, 32'h5A5A5A5A, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b0);
        expect_term(K_ACK, 32'h0, 1'b0);
        burst(1'b1, 32'h80, 32'h100, 2'b00, 4, 2);
        expect_term(K_ACK, 32'h100, 1'b1);
        classic(1'b0, 32'h80, 32'h0, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h101, 1'b1);
        classic(1'b0, 32'h84, 32'h0, 4'hF, 1'b0);
        expect_term(K_ACK, 32'h5A5A5A5A, 1'b1);
        classic(1'b0, 32'h88, 32'h0, 4'hF, 1'b0);

        // Random full writes, partial overwrite, read back against a byte-merge model
        for (int i = 0; i < 6; i++) begin
            widx  = $urandom_range(64, 127);
            full  = $urandom;
            part  = $urandom;
            s     = 4'($urandom_range(0, 15));
            model = full;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model[8*b +: 8] = part[8*b +: 8];
            end
            expect_term(K_ACK, 32'h0, 1'b0);
            classic(1'b1, 32'(widx * 4), full, 4'hF, 1'b0);
            expect_term(K_ACK, 32'h0, 1'b0);
            classic(1'b1, 32'(widx * 4), part, s, 1'b0);
            expect_term(K_ACK, model, 1'b1);
            classic(1'b0, 32'(widx * 4), 32'h0, 4'hF, 1'b0);
        end

        // Reset during a wait state on the three-wait-state instance
        dut_sel = 1'b1;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20; sel = 4'hF; cti = 3'b000;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_in_wait", 64'({ack_b, err_b, rty_b}), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        expect_term(K_ACK, 32'hFF22FF44, 1'b1);
        classic(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        dut_sel = 1'b0;

        // Reset while a burst beat is being acked clears the outputs at once
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack_a && n < 40);
        check("rst_burst_ack_seen", 64'(ack_a), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_burst", 64'({ack_a, err_a, rty_a}), 64'd0);
        check("rst_mid_burst_dat", 64'(dat_a), 64'd0);
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_term(K_ACK, 32'd4, 1'b1);
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_slave_mem.md
Name: wb_slave_mem

Overview:
- Wishbone B4 slave (responder) backed by an internal word-addressed memory.
- Terminates cycles from the team's Wishbone initiator.
- Supports classic single cycles and registered-feedback incrementing bursts (CTI/BTE), with programmable wait states, error and retry terminations.
- Serves as the bench/target endpoint for bridge work and as a standalone scratch RAM.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two, at least 16.
- BASE_ADDR, 32'h0000_0000, byte base address of the window; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0, extra cycles inserted before the first ack/err of each cycle; range 0..15.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe/transfer valid.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  32  byte address.
- dat_i  in  32  write data.
- sel_i  in  4  byte enables; bit n covers dat[8n+7:8n].
- cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst, others treated as classic.
- bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- hold_i  in  1  target busy; a new cycle that starts while high is retried.
- dat_o  out  32  read data, valid only with ack_o.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- rty_o  out  1  retry termination.

Behaviour:
- Reset (async assert, synchronous release): state IDLE. ack_o, err_o, rty_o and dat_o all 0. Wait counter and burst address 0. Memory contents undefined.
- Only one of ack_o/err_o/rty_o is ever high. All three are registered outputs. dat_o is 0 whenever ack_o is 0.
- Address decode:
  - Hit when adr_i - BASE_ADDR < DEPTH_WORDS*4 and adr_i[1:0] == 0.
  - Word index = (adr_i - BASE_ADDR) >> 2.
- States: IDLE, WAIT, SINGLE, BURST, TERM.
- IDLE: on cyc_i&stb_i, the first matching rule applies:
  - hold_i = 1: go to TERM with rty_o = 1 next cycle.
  - Decode miss: go to WAIT (count = WAIT_STATES), then err_o.
  - Otherwise: go to WAIT, then ack_o.
- Latency: the request is sampled in cycle N; the termination is high in cycle N+1+WAIT_STATES for exactly one cycle (classic).
- hold_i is sampled only in IDLE; it is ignored once a cycle is accepted.
- Write commit:
  - Happens on the rising edge where ack_o = 1, stb_i = 1 and we_i = 1.
  - Only bytes with sel_i = 1 are written.
  - sel_i = 0000 acks with no write.
- Read: memory is read in the cycle before ack; dat_o carries the full word regardless of sel_i.
- Classic (cti != 010 at first beat): SINGLE asserts the termination for one cycle, then IDLE. The cycle after any termination never re-acks; a new request is sampled again from IDLE.
- Incrementing burst (cti_i = 010 at first beat):
  - After the first ack, enter BURST.
  - ack_o stays high every cycle that stb_i is high, using the internal burst address.
  - The burst address advances by one word per acked beat.
  - bte_i wrap: index bits [1:0], [2:0] or [3:0] increment modulo 4, 8 or 16; upper bits are held. Linear increments the full index.
  - stb_i low in BURST: ack_o drops, the address holds, and the burst resumes when stb_i returns.
  - A beat acked with cti_i = 111 ends the burst; go to IDLE.
  - Linear burst advancing past the window: that beat gets err_o instead of ack, with no write, then IDLE.
  - Wait states apply only before the first beat.
- cyc_i low in any state: next state IDLE, all outputs 0 next cycle, no write on that edge.
- rst_i asserted mid-burst: outputs clear immediately; memory is not cleared.

Decomposition:
- Package wb_pkg holds:
  - cti_e enum: CLASSIC = 3'b000, CONST = 3'b001, INCR = 3'b010, EOB = 3'b111.
  - bte_e enum: LINEAR, WRAP4, WRAP8, WRAP16.
  - wb_state_e enum for the FSM.
  - Function next_burst_idx(idx, bte), shared with future bridge blocks.
- One sub-module, wb_mem_bytewr: single-port synchronous RAM with 4-bit byte write enable and registered read.

Test Plan:
- WAIT_STATES = 0, classic write to 0x10 of 0xDEADBEEF with sel = 1111, then classic read of 0x10:
  - Each ack is high exactly 1 cycle, 1 cycle after the request.
  - Read returns dat_o = 0xDEADBEEF.
- WAIT_STATES = 3, write 0x11223344 with sel = 0101 over a prior 0xFFFFFFFF at 0x20, then read back:
  - ack appears 4 cycles after the request.
  - Read returns 0xFF22FF44.
- Preload words 0..15 with their index. Incrementing read burst at 0x38 (word 14), bte = 01 (wrap4), 4 beats, the last with cti = 111:
  - ack_o is continuous.
  - Data sequence is 14, 15, 12, 13.
  - Returns to IDLE after beat 4.
- Error terminations:
  - Read at BASE_ADDR + DEPTH_WORDS*4: single-cycle err_o, no ack, dat_o = 0.
  - Read at 0x02: err_o.
  - Linear burst starting at the last word: ack on beat 1, err_o on beat 2, no write.
- Retry: hold_i = 1 when a write request arrives:
  - rty_o high 1 cycle, no memory change.
  - Retrying with hold_i = 0 completes with ack.
- Abort and reset:
  - Drop cyc_i mid-burst after 2 beats: outputs 0 next cycle, no 3rd write.
  - Assert rst_i during a WAIT state: ack_o, err_o and rty_o go 0 asynchronously.
